// File: rtl/alu_step_sequencer_if.sv
// Handshake and datapath signals between decode, the ALU step sequencer and the datapath.
// master: decode/datapath side; slave: the sequencer.
interface alu_step_sequencer_if;
    logic        start;
    logic [4:0]  opcode;
    logic        ready;
    logic        done;
    logic        error;
    logic        rb_out;
    logic        rc_out;
    logic        y_in;
    logic [4:0]  alu_control;
    logic        z_in;
    logic        z_lo_out;
    logic        z_hi_out;
    logic        ra_in;
    logic        lo_in;
    logic        hi_in;
    logic [63:0] z_data_in;
    logic [31:0] z_bus_out;

    modport master (
        output start, opcode, z_data_in,
        input  ready, done, error, rb_out, rc_out, y_in, alu_control, z_in,
        input  z_lo_out, z_hi_out, ra_in, lo_in, hi_in, z_bus_out
    );

    modport slave (
        input  start, opcode, z_data_in,
        output ready, done, error, rb_out, rc_out, y_in, alu_control, z_in,
        output z_lo_out, z_hi_out, ra_in, lo_in, hi_in, z_bus_out
    );
endinterface

// File: rtl/alu_step_sequencer.sv
// Sequences Y-load, ALU-operate and Z-writeback for one register-to-register ALU instruction.
// Define ALU_SEQ_MULDIV_WAIT_EN to add MULDIV_WAIT settle cycles (T_WAIT) for mul/div.
module alu_step_sequencer #(
    parameter int unsigned MULDIV_WAIT = 2
) (
    input logic              clock,
    input logic              clear,
    alu_step_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle, StY, StOp, StWait, StLo, StHi, StDone, StErr
    } state_e;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == 5'b01111) || (op == 5'b10000);
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return (op == 5'b10001) || (op == 5'b10010);
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return ((op >= 5'b00011) && (op <= 5'b01011)) || is_muldiv(op) || is_unary(op);
    endfunction

    state_e      state_q, state_d;
    logic [4:0]  op_q, op_d;
    logic [63:0] z_q;
    logic        ready_q, ready_d, done_q, done_d, error_q, error_d;
    logic        rb_out_q, rb_out_d, rc_out_q, rc_out_d, y_in_q, y_in_d;
    logic        z_in_q, z_in_d, z_lo_out_q, z_lo_out_d, z_hi_out_q, z_hi_out_d;
    logic        ra_in_q, ra_in_d, lo_in_q, lo_in_d, hi_in_q, hi_in_d;
    logic [4:0]  alu_control_q, alu_control_d;
`ifdef ALU_SEQ_MULDIV_WAIT_EN
    logic [3:0]  cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
`ifdef ALU_SEQ_MULDIV_WAIT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle, StDone, StErr: begin
                state_d = StIdle;
                if (bus.start) begin
                    op_d    = bus.opcode;
                    state_d = is_legal(bus.opcode) ? StY : StErr;
                end
            end
            StY: state_d = StOp;
            StOp: begin
                state_d = StLo;
`ifdef ALU_SEQ_MULDIV_WAIT_EN
                if (is_muldiv(op_q)) begin
                    state_d = StWait;
                    cnt_d   = 4'(MULDIV_WAIT - 1);
                end
`endif
            end
`ifdef ALU_SEQ_MULDIV_WAIT_EN
            StWait: begin
                if (cnt_q == 4'd0) state_d = StLo;
                else               cnt_d   = cnt_q - 4'd1;
            end
`endif
            StLo:    state_d = is_muldiv(op_q) ? StHi : StDone;
            StHi:    state_d = StDone;
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they leave the flops aligned with it.
        ready_d       = (state_d == StIdle) || (state_d == StDone) || (state_d == StErr);
        done_d        = (state_d == StDone);
        error_d       = (state_d == StErr);
        rb_out_d      = (state_d == StY);
        y_in_d        = (state_d == StY);
        rc_out_d      = ((state_d == StOp) && !is_unary(op_d)) || (state_d == StWait);
        alu_control_d = ((state_d == StOp) || (state_d == StWait)) ? op_d : 5'd0;
`ifdef ALU_SEQ_MULDIV_WAIT_EN
        z_in_d        = ((state_d == StOp) && !is_muldiv(op_d)) ||
                        ((state_d == StWait) && (cnt_d == 4'd0));
`else
        z_in_d        = (state_d == StOp);
`endif
        z_lo_out_d    = (state_d == StLo);
        ra_in_d       = (state_d == StLo) && !is_muldiv(op_d);
        lo_in_d       = (state_d == StLo) && is_muldiv(op_d);
        z_hi_out_d    = (state_d == StHi);
        hi_in_d       = (state_d == StHi);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q       <= StIdle;
            op_q          <= 5'd0;
            z_q           <= 64'd0;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            rb_out_q      <= 1'b0;
            rc_out_q      <= 1'b0;
            y_in_q        <= 1'b0;
            alu_control_q <= 5'd0;
            z_in_q        <= 1'b0;
            z_lo_out_q    <= 1'b0;
            z_hi_out_q    <= 1'b0;
            ra_in_q       <= 1'b0;
            lo_in_q       <= 1'b0;
            hi_in_q       <= 1'b0;
`ifdef ALU_SEQ_MULDIV_WAIT_EN
            cnt_q         <= 4'd0;
`endif
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            if (z_in_q) z_q <= bus.z_data_in;
            ready_q       <= ready_d;
            done_q        <= done_d;
            error_q       <= error_d;
            rb_out_q      <= rb_out_d;
            rc_out_q      <= rc_out_d;
            y_in_q        <= y_in_d;
            alu_control_q <= alu_control_d;
            z_in_q        <= z_in_d;
            z_lo_out_q    <= z_lo_out_d;
            z_hi_out_q    <= z_hi_out_d;
            ra_in_q       <= ra_in_d;
            lo_in_q       <= lo_in_d;
            hi_in_q       <= hi_in_d;
`ifdef ALU_SEQ_MULDIV_WAIT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    always_comb begin
        bus.z_bus_out = 32'd0;
        if (z_lo_out_q)      bus.z_bus_out = z_q[31:0];
        else if (z_hi_out_q) bus.z_bus_out = z_q[63:32];
    end

    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.rb_out      = rb_out_q;
    assign bus.rc_out      = rc_out_q;
    assign bus.y_in        = y_in_q;
    assign bus.alu_control = alu_control_q;
    assign bus.z_in        = z_in_q;
    assign bus.z_lo_out    = z_lo_out_q;
    assign bus.z_hi_out    = z_hi_out_q;
    assign bus.ra_in       = ra_in_q;
    assign bus.lo_in       = lo_in_q;
    assign bus.hi_in       = hi_in_q;

endmodule

// File: doc/alu_step_sequencer.md
Name: alu_step_sequencer

Overview:
- Drives the control side of the ALU and receives its result: sequences the Y-load, ALU-operate and Z-writeback steps of one register-to-register ALU instruction.
- Owns the 64-bit Z register that captures the ALU's 64-bit output and gates its low or high half onto the 32-bit bus.
- Sits between the instruction-decode control logic (start/opcode handshake) and the datapath (register out/in strobes, Y register, ALU, HI/LO).

Parameters:
- MULDIV_WAIT, 2: extra settle cycles for mul/div. Used only when ALU_SEQ_MULDIV_WAIT_EN is defined; legal range 1..15.

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  synchronous active-high reset
- start  in  1  request; accepted when start && ready
- opcode  in  5  ALU operation code, sampled on accept
- ready  out  1  idle and able to accept
- done  out  1  one-cycle pulse; instruction completed
- error  out  1  one-cycle pulse; illegal opcode accepted
- rb_out  out  1  drive Rb onto bus
- rc_out  out  1  drive Rc onto bus
- y_in  out  1  load Y from bus
- alu_control  out  5  operation code to ALU
- z_in  out  1  internal Z capture strobe, mirrored as output
- z_lo_out  out  1  Z[31:0] onto bus
- z_hi_out  out  1  Z[63:32] onto bus
- ra_in  out  1  load Ra from bus
- lo_in  out  1  load LO from bus
- hi_in  out  1  load HI from bus
- z_data_in  in  64  ALU result
- z_bus_out  out  32  Z half selected for bus; 0 when neither out strobe is high

Behaviour:
- Legal opcodes:
  - Binary: 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol.
  - Mul/div: 01111 mul, 10000 div.
  - Unary: 10001 neg, 10010 not.
  - All other codes are illegal.
- Reset (clear high at an edge): state IDLE; ready=1; all strobes, done, error = 0; alu_control=0; Z register=0; latched opcode=0. Takes priority over everything, including mid-instruction; no done or error is issued for an aborted instruction.
- FSM states: IDLE, T_Y, T_OP, T_WAIT (macro only), T_LO, T_HI, T_DONE, T_ERR.
- IDLE:
  - ready=1.
  - On start: latch opcode. Go to T_ERR if the opcode is illegal, else T_Y.
  - start while not ready is ignored; it is not queued.
- T_Y: rb_out=1, y_in=1.
- T_OP:
  - rc_out=1 for binary and mul/div ops; rc_out=0 for unary ops.
  - alu_control=latched opcode; z_in=1.
  - Z register loads z_data_in at the closing edge.
  - Next state: T_LO, or T_WAIT for mul/div when the macro is defined.
- T_LO:
  - z_lo_out=1.
  - ra_in=1 for non-mul/div; lo_in=1 for mul/div.
  - Next: T_HI for mul/div, else T_DONE.
- T_HI: z_hi_out=1, hi_in=1. Next: T_DONE.
- T_DONE: done=1, ready=1, and IDLE behaviour applies: a start in this cycle is accepted and goes directly to T_Y or T_ERR.
- T_ERR: error=1, no datapath strobes, ready=1, IDLE behaviour applies.
- alu_control = latched opcode in T_OP and T_WAIT; 0 in every other state.
- Strobes are registered-state decodes and never glitch across states. At most one bus driver (rb_out, rc_out, z_lo_out, z_hi_out) is high in any cycle.
- Z register changes only on z_in or clear; its value persists across instructions.
- Latency from the accept edge (cycle 0):
  - Non-mul/div: T_Y=1, T_OP=2, T_LO=3, done=4.
  - Mul/div: T_LO=3, T_HI=4, done=5.
  - Illegal opcode: error=1.

Optional Feature:
- Macro ALU_SEQ_MULDIV_WAIT_EN.
- Defined, mul/div only:
  - T_OP asserts rc_out and alu_control but not z_in.
  - T_WAIT holds rc_out=1 and alu_control for MULDIV_WAIT cycles, using an internal down-counter.
  - z_in is asserted only in the last T_WAIT cycle, then the FSM goes to T_LO.
  - Mul/div done moves to cycle 5+MULDIV_WAIT.
  - clear during T_WAIT aborts as above.
- Undefined: T_WAIT and the counter are absent; timing is exactly as in Behaviour.

Test Plan:
- Reset: clear for 2 cycles -> ready=1, all strobes 0, z_bus_out=0.
- add: start with opcode=00011; bench ALU returns z_data_in=64'h0000_0000_0000_000C -> rb_out/y_in@1; rc_out/z_in/alu_control=00011@2; z_lo_out/ra_in@3 with z_bus_out=32'h0000_000C; done@4.
- mul: opcode=01111, z_data_in=64'h0000_0001_FFFF_FFFE -> lo_in@3 with z_bus_out=32'hFFFF_FFFE; hi_in@4 with z_bus_out=32'h0000_0001; done@5.
- Unary not and illegal opcode:
  - opcode=10010 -> rc_out stays 0 throughout, z_in@2, ra_in@3.
  - opcode=01100 -> error@1, no strobes, ready=1.
- Back-to-back and clear mid-op:
  - start held high continuously -> second instruction's rb_out in the cycle after done.
  - clear asserted in T_OP of a div -> IDLE next cycle, Z=0, no done.
- Macro defined, MULDIV_WAIT=3, opcode=10000 -> rc_out@2..5, z_in@5 only, lo_in@6, hi_in@7, done@8.
